mapper: RTL and testbench
=========================

// Module: mapper
// PURPOSE
//   Transaction-ID -> ingress-port lookup table for the MemorEDF scheduler.
//   Up to four insert channels record which port each AXI ID arrived on. Two
//   independent lookup channels (write path, read path) return that port so
//   responses can be routed back. Table has one entry per ID and no eviction;
//   an entry is overwritten only by a later insert of the same ID.
// PARAMETERS
//   ID_WIDTH         6  width of an ID; table depth = 2**ID_WIDTH entries
//   NUMBER_OF_PORTS  2  number of ingress ports
//   PW (localparam)  port field width = max(1, $clog2(NUMBER_OF_PORTS))
// PORTS
//   clock             in   1         single clock, rising edge
//   reset             in   1         asynchronous, active-high; clears table
//   id_N   (N=1..4)   in   ID_WIDTH  ID to insert on channel N
//   port_N (N=1..4)   in   PW        port that ID came from
//   valid_N (N=1..4)  in   1         insert strobe for channel N
//   write_look_after  in   ID_WIDTH  ID queried by write-response path
//   write_came_from   out  PW        port stored for write_look_after
//   read_look_after   in   ID_WIDTH  ID queried by read-response path
//   read_came_from    out  PW        port stored for read_look_after
// BEHAVIOUR
//   - Storage: 2**ID_WIDTH entries of PW bits (no valid bits).
//   - Reset: asynchronous assert clears every entry and both *_came_from
//     outputs to 0 immediately; operation resumes on first rising edge after
//     deassertion.
//   - Insert: on rising edge, each channel with valid_N=1 writes
//     table[id_N] <= port_N. Channels are independent; no handshake/backpressure.
//   - Same-edge collision (two channels, same ID): highest N wins
//     (id_4 > id_3 > id_2 > id_1). Different IDs all write that edge.
//   - Lookup: registered, 1-cycle latency. On each rising edge
//     write_came_from <= table[write_look_after],
//     read_came_from  <= table[read_look_after]. Outputs hold between edges.
//   - Lookup and insert of same ID on same edge: lookup returns the value
//     prior to that edge (read-before-write); new value visible next cycle.
//   - Never-inserted ID returns 0 (reset value).
//   - Both lookup channels may address the same or different IDs every cycle;
//     no conflict between them.
//   - port_N values >= NUMBER_OF_PORTS are stored as given (no checking).
// TESTING
//   1 Reset: assert reset, query IDs 0x00, 0x3F on both paths -> both outputs 0.
//   2 Dual insert: edge with id_1=0x21/port_1=1/valid_1=1 and
//     id_2=0x20/port_2=0/valid_2=1 -> lookup 0x21 gives 1, 0x20 gives 0,
//     one cycle after look_after applied.
//   3 Unwritten entry: after test 2, lookup ID 12 -> 0.
//   4 Collision: same edge id_1=id_4=0x05, port_1=0, port_4=1, both valid
//     -> lookup 0x05 returns 1; then id_1=0x05/port_1=0 alone -> returns 0.
//   5 Read-before-write: insert 0x10->1 while querying 0x10 on same edge
//     -> output 0 that cycle, 1 on next cycle.
//   6 Dual lookup + mid-run reset: write path 0x21, read path 0x20 together
//     -> 1 and 0; assert reset between edges -> outputs 0 at once, 0x21
//     returns 0 after reset.

Source files
------------

// File: rtl/mapper_if.sv
// mapper_if: insert and lookup bundle for the ID -> port lookup table.
//   id_N / port_N / valid_N (N=1..4) : insert channels (ID, originating port, strobe)
//   write_look_after / read_look_after : IDs queried by the two response paths
//   write_came_from / read_came_from   : registered lookup results
// The master modport drives inserts and queries. The slave modport is the table.
interface mapper_if #(
    parameter int ID_WIDTH        = 6,
    parameter int NUMBER_OF_PORTS = 2
);
    localparam int PW = (NUMBER_OF_PORTS > 1) ? $clog2(NUMBER_OF_PORTS) : 1;

    logic [ID_WIDTH-1:0] id_1, id_2, id_3, id_4;
    logic [PW-1:0]       port_1, port_2, port_3, port_4;
    logic                valid_1, valid_2, valid_3, valid_4;
    logic [ID_WIDTH-1:0] write_look_after;
    logic [PW-1:0]       write_came_from;
    logic [ID_WIDTH-1:0] read_look_after;
    logic [PW-1:0]       read_came_from;

    modport master (
        output id_1, id_2, id_3, id_4,
        output port_1, port_2, port_3, port_4,
        output valid_1, valid_2, valid_3, valid_4,
        output write_look_after, read_look_after,
        input  write_came_from, read_came_from
    );

    modport slave (
        input  id_1, id_2, id_3, id_4,
        input  port_1, port_2, port_3, port_4,
        input  valid_1, valid_2, valid_3, valid_4,
        input  write_look_after, read_look_after,
        output write_came_from, read_came_from
    );
endinterface

// File: rtl/mapper.sv
// mapper: transaction-ID -> ingress-port lookup table.
//   clock : rising-edge clock
//   reset : asynchronous, active-high; clears every entry and both outputs
//   bus   : mapper_if slave. It carries four insert channels and two
//           independent lookup paths, write and read.
// Each ID has one entry and no valid bit, so an ID that was never inserted
// reads back as 0. Lookups are registered and take one cycle. A lookup that
// hits an ID being inserted on the same edge returns the old contents.
module mapper #(
    parameter int ID_WIDTH        = 6,
    parameter int NUMBER_OF_PORTS = 2
) (
    input  logic    clock,
    input  logic    reset,
    mapper_if.slave bus
);
    localparam int PW    = (NUMBER_OF_PORTS > 1) ? $clog2(NUMBER_OF_PORTS) : 1;
    localparam int DEPTH = 2 ** ID_WIDTH;

    logic [PW-1:0] entries [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            bus.write_came_from <= '0;
            bus.read_came_from  <= '0;
        end else begin
            // Lookup reads the array before this edge's inserts land (read-before-write).
            bus.write_came_from <= entries[bus.write_look_after];
            bus.read_came_from  <= entries[bus.read_look_after];

            // Later nonblocking writes to the same entry override earlier ones.
            // Ordering the channels 1..4 therefore lets the highest channel win a collision.
            if (bus.valid_1) entries[bus.id_1] <= bus.port_1;
            if (bus.valid_2) entries[bus.id_2] <= bus.port_2;
            if (bus.valid_3) entries[bus.id_3] <= bus.port_3;
            if (bus.valid_4) entries[bus.id_4] <= bus.port_4;
        end
    end
endmodule

// File: tb/tb_mapper.sv
module tb_mapper;
    localparam int IDW = 6;
    localparam int NP  = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mapper_if #(.ID_WIDTH(IDW), .NUMBER_OF_PORTS(NP)) bus ();

    mapper #(.ID_WIDTH(IDW), .NUMBER_OF_PORTS(NP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: the contents of each ID's entry, as the spec rules describe them.
    int model [64];

    typedef struct {
        logic [3:0]       v;
        logic [3:0][5:0]  id;
        logic [3:0]       pt;
        logic [5:0]       wl;
        logic [5:0]       rl;
        int               exp_w;
        int               exp_r;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) model[i] = 0;
    endtask

    // Drive one cycle of inserts and lookups. The expected outputs come from
    // the model's state before the edge, which models read-before-write.
    task automatic drive_cycle(input logic [3:0] v, input logic [3:0][5:0] id,
                               input logic [3:0] pt, input logic [5:0] wl,
                               input logic [5:0] rl, output int mw, output int mr);
        @(negedge clock);
        bus.valid_1 = v[0]; bus.id_1 = id[0]; bus.port_1 = pt[0];
        bus.valid_2 = v[1]; bus.id_2 = id[1]; bus.port_2 = pt[1];
        bus.valid_3 = v[2]; bus.id_3 = id[2]; bus.port_3 = pt[2];
        bus.valid_4 = v[3]; bus.id_4 = id[3]; bus.port_4 = pt[3];
        bus.write_look_after = wl;
        bus.read_look_after  = rl;
        mw = model[wl];
        mr = model[rl];
        for (int c = 0; c < 4; c++)
            if (v[c]) model[id[c]] = pt[c];
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0][5:0] id,
                                input logic [3:0] pt, input logic [5:0] wl,
                                input logic [5:0] rl, input int ew, input int er);
        vec_t r;
        r.v = v; r.id = id; r.pt = pt; r.wl = wl; r.rl = rl;
        r.exp_w = ew; r.exp_r = er;
        return r;
    endfunction

    initial begin
        int mw, mr;
        logic [3:0]      rv;
        logic [3:0][5:0] rid;
        logic [3:0]      rpt;
        logic [5:0]      rwl, rrl;

        // The id field is {ch4, ch3, ch2, ch1}. Expected values are written out by hand.
        vecs.push_back(mk(4'b0011, {6'h00, 6'h00, 6'h20, 6'h21}, 4'b0001, 6'h21, 6'h20, 0, 0));
        vecs.push_back(mk(4'b0000, {6'h00, 6'h00, 6'h00, 6'h00}, 4'b0000, 6'h21, 6'h20, 1, 0));
        vecs.push_back(mk(4'b0000, {6'h00, 6'h00, 6'h00, 6'h00}, 4'b0000, 6'd12, 6'd12, 0, 0));
        vecs.push_back(mk(4'b1001, {6'h05, 6'h00, 6'h00, 6'h05}, 4'b1000, 6'h05, 6'h05, 0, 0));
        vecs.push_back(mk(4'b0000, {6'h00, 6'h00, 6'h00, 6'h00}, 4'b0000, 6'h05, 6'h05, 1, 1));
        vecs.push_back(mk(4'b0001, {6'h00, 6'h00, 6'h00, 6'h05}, 4'b0000, 6'h05, 6'h05, 1, 1));
        vecs.push_back(mk(4'b0000, {6'h00, 6'h00, 6'h00, 6'h00}, 4'b0000, 6'h05, 6'h05, 0, 0));
        vecs.push_back(mk(4'b0010, {6'h00, 6'h00, 6'h10, 6'h00}, 4'b0010, 6'h10, 6'h10, 0, 0));
        vecs.push_back(mk(4'b0000, {6'h00, 6'h00, 6'h00, 6'h00}, 4'b0000, 6'h10, 6'h21, 1, 1));
        vecs.push_back(mk(4'b0110, {6'h00, 6'h3F, 6'h3F, 6'h00}, 4'b0100, 6'h3F, 6'h20, 0, 0));
        vecs.push_back(mk(4'b0000, {6'h00, 6'h00, 6'h00, 6'h00}, 4'b0000, 6'h3F, 6'h20, 1, 0));
        vecs.push_back(mk(4'b1100, {6'h2A, 6'h2A, 6'h00, 6'h00}, 4'b0100, 6'h2A, 6'h3F, 0, 1));
        vecs.push_back(mk(4'b0000, {6'h00, 6'h00, 6'h00, 6'h00}, 4'b0000, 6'h2A, 6'h2A, 0, 0));

        bus.valid_1 = 0; bus.valid_2 = 0; bus.valid_3 = 0; bus.valid_4 = 0;
        bus.id_1 = 0; bus.id_2 = 0; bus.id_3 = 0; bus.id_4 = 0;
        bus.port_1 = 0; bus.port_2 = 0; bus.port_3 = 0; bus.port_4 = 0;
        bus.write_look_after = 6'h00;
        bus.read_look_after  = 6'h3F;
        clear_model();

        // Reset held across edges: both outputs stay 0.
        repeat (3) @(posedge clock);
        #1;
        check("reset_write", int'(bus.write_came_from), 0);
        check("reset_read",  int'(bus.read_came_from), 0);
        @(negedge clock);
        reset = 1'b0;

        // Directed table.
        foreach (vecs[i]) begin
            drive_cycle(vecs[i].v, vecs[i].id, vecs[i].pt, vecs[i].wl, vecs[i].rl, mw, mr);
            check($sformatf("vec%0d_write", i), int'(bus.write_came_from), vecs[i].exp_w);
            check($sformatf("vec%0d_read", i),  int'(bus.read_came_from),  vecs[i].exp_r);
            check($sformatf("vec%0d_model", i), mw, vecs[i].exp_w);
        end

        // Dual lookup, then a reset pulse between edges.
        drive_cycle(4'b0000, '0, 4'b0000, 6'h21, 6'h20, mw, mr);
        check("dual_write", int'(bus.write_came_from), 1);
        check("dual_read",  int'(bus.read_came_from), 0);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_reset_write", int'(bus.write_came_from), 0);
        check("async_reset_read",  int'(bus.read_came_from), 0);
        clear_model();
        @(negedge clock);
        reset = 1'b0;
        drive_cycle(4'b0000, '0, 4'b0000, 6'h21, 6'h10, mw, mr);
        check("post_reset_21", int'(bus.write_came_from), 0);
        check("post_reset_10", int'(bus.read_came_from), 0);

        // Randomized traffic checked against the model. About half the IDs are
        // drawn from a small pool so that channel collisions and hits on
        // recently inserted IDs happen often.
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < 4; c++) begin
                rv[c]  = ($urandom_range(0, 2) != 0);
                rid[c] = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7))
                                                     : 6'($urandom_range(0, 63));
                rpt[c] = 1'($urandom_range(0, 1));
            end
            rwl = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            rrl = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            drive_cycle(rv, rid, rpt, rwl, rrl, mw, mr);
            check($sformatf("rand%0d_write", k), int'(bus.write_came_from), mw);
            check($sformatf("rand%0d_read", k),  int'(bus.read_came_from), mr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
